// File: rtl/negator_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : negator_pkg
//  Description : Shared types for the chunked two's-complement negator:
//                operation modes, FSM states and the invert decision.
//  Revision    : 1.0  initial release
// ============================================================================
package negator_pkg;

    // Operation modes; the unnamed code 2'b11 behaves as negate
    typedef enum logic [1:0] {
        MODE_PASS = 2'b00,
        MODE_NEG  = 2'b01,
        MODE_ABS  = 2'b10
    } neg_mode_t;

    // Top-level control states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } neg_state_t;

    // True when the operand must be inverted-and-incremented
    function automatic logic needs_invert(input logic [1:0] mode, input logic sign);
        return (mode == MODE_NEG) || (mode == 2'b11) || ((mode == MODE_ABS) && sign);
    endfunction

endpackage
`default_nettype wire

// File: rtl/chunk_inv_inc.sv
`default_nettype none
// ============================================================================
//  Module      : chunk_inv_inc
//  Description : CHUNK-bit conditional invert plus carry-in increment.
//                One slice of the multi-cycle two's-complement datapath.
//  Revision    : 1.0  initial release
// ============================================================================
module chunk_inv_inc #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] op,
    input  logic             inv,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    logic [CHUNK:0] w_total;

    // One extra bit holds the carry into the next chunk
    assign w_total = {1'b0, op ^ {CHUNK{inv}}} + {{CHUNK{1'b0}}, cin};
    assign {cout, sum} = w_total;

endmodule
`default_nettype wire

// File: rtl/chunked_twos_negator.sv
`default_nettype none
// ============================================================================
//  Module      : chunked_twos_negator
//  Description : Multi-cycle two's-complement pass/negate/abs unit. Processes
//                CHUNK bits per cycle through a registered carry, one operand
//                in flight, valid/ready on both sides.
//                Optional macro NEG_OVF_EN: negating the most-negative operand
//                saturates to 0111..1 and raises out_ovf; otherwise the result
//                wraps to 1000..0 and out_ovf stays 0.
//  Revision    : 1.0  initial release
// ============================================================================
module chunked_twos_negator
    import negator_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf
);

    localparam int               c_NCHUNK   = WIDTH / CHUNK;
    localparam int               c_IDX_W    = (c_NCHUNK > 1) ? $clog2(c_NCHUNK) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_NCHUNK - 1);
    localparam logic [WIDTH-1:0] c_MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] c_SAT      = {1'b0, {(WIDTH-1){1'b1}}};

    neg_state_t         r_state;
    logic [WIDTH-1:0]   r_op;
    logic [CHUNK-1:0]   r_res [c_NCHUNK];
    logic [c_IDX_W-1:0] r_idx;
    logic               r_carry;
    logic               r_inv;
    logic               r_out_valid;

    logic [CHUNK-1:0]   w_op_chunks [c_NCHUNK];
    logic [CHUNK-1:0]   w_sum;
    logic               w_cout;
    logic               w_inv;

`ifdef NEG_OVF_EN
    logic               r_ovf_hit;
    logic               r_ovf;
`endif

    // Split the latched operand into chunks and reassemble the result
    for (genvar g = 0; g < c_NCHUNK; g++) begin : g_chunks
        assign w_op_chunks[g]              = r_op[g*CHUNK +: CHUNK];
        assign out_data[g*CHUNK +: CHUNK] = r_res[g];
    end

    assign w_inv     = needs_invert(in_mode, in_data[WIDTH-1]);
    assign in_ready  = (r_state == IDLE);
    assign out_valid = r_out_valid;

`ifdef NEG_OVF_EN
    assign out_ovf = r_ovf;
`else
    assign out_ovf = 1'b0;
`endif

    // Single shared slice; the chunk under work is picked by r_idx
    chunk_inv_inc #(
        .CHUNK (CHUNK)
    ) u_slice (
        .op   (w_op_chunks[r_idx]),
        .inv  (r_inv),
        .cin  (r_carry),
        .sum  (w_sum),
        .cout (w_cout)
    );

    // Control FSM with operand, result, index and carry registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_op        <= '0;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_inv       <= 1'b0;
            r_out_valid <= 1'b0;
            for (int i = 0; i < c_NCHUNK; i++) begin
                r_res[i] <= '0;
            end
`ifdef NEG_OVF_EN
            r_ovf_hit   <= 1'b0;
            r_ovf       <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_op    <= in_data;
                        r_inv   <= w_inv;
                        r_carry <= w_inv;
                        r_idx   <= '0;
                        r_state <= CALC;
`ifdef NEG_OVF_EN
                        r_ovf_hit <= w_inv && (in_data == c_MOST_NEG);
                        r_ovf     <= 1'b0;
`endif
                    end
                end
                CALC: begin
                    r_res[r_idx] <= w_sum;
                    r_carry      <= w_cout;
                    if (r_idx == c_LAST_IDX) begin
                        // Final carry-out is dropped: result is modulo 2^WIDTH
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
`ifdef NEG_OVF_EN
                        r_ovf <= r_ovf_hit;
                        if (r_ovf_hit) begin
                            for (int i = 0; i < c_NCHUNK; i++) begin
                                r_res[i] <= c_SAT[i*CHUNK +: CHUNK];
                            end
                        end
`endif
                    end else begin
                        r_idx <= r_idx + c_IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_chunked_twos_negator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_chunked_twos_negator
//  Description : Scoreboard bench: a 6-bit/2-bit instance for directed
//                corner cases and a 16-bit/4-bit instance for wide vectors
//                and back-to-back issue spacing. Honours NEG_OVF_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_chunked_twos_negator;
    import negator_pkg::*;

    typedef struct packed {
        logic [15:0] d;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Narrow instance signals
    logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_ovf;
    logic [5:0] a_in_data, a_out_data;
    logic [1:0] a_in_mode;

    // Wide instance signals
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_ovf;
    logic [15:0] b_in_data, b_out_data;
    logic [1:0]  b_in_mode;

    exp_t qa[$];
    exp_t qb[$];
    int   a_acc_cyc = 0;
    int   a_hs_cyc  = 0;
    int   b_acc[$];

`ifdef NEG_OVF_EN
    localparam logic [5:0]  A_MIN_RES = 6'b011111;
    localparam logic        A_MIN_OVF = 1'b1;
    localparam logic [15:0] B_MIN_RES = 16'h7FFF;
    localparam logic        B_MIN_OVF = 1'b1;
`else
    localparam logic [5:0]  A_MIN_RES = 6'b100000;
    localparam logic        A_MIN_OVF = 1'b0;
    localparam logic [15:0] B_MIN_RES = 16'h8000;
    localparam logic        B_MIN_OVF = 1'b0;
`endif

    // Wide directed vectors with hand-computed results
    localparam int NB = 9;
    logic [15:0] bv_d [NB] = '{16'h1234, 16'h8000, 16'hFFFF, 16'h00F0, 16'hABCD,
                               16'h0001, 16'h7FFF, 16'h8001, 16'h0100};
    logic [1:0]  bv_m [NB] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b00,
                               2'b11, 2'b01, 2'b10, 2'b01};
    logic [15:0] bv_e [NB] = '{16'hEDCC, B_MIN_RES, 16'h0001, 16'h00F0, 16'hABCD,
                               16'hFFFF, 16'h8001, 16'h7FFF, 16'hFF00};
    logic        bv_o [NB] = '{1'b0, B_MIN_OVF, 1'b0, 1'b0, 1'b0,
                               1'b0, 1'b0, 1'b0, 1'b0};

    chunked_twos_negator #(.WIDTH(6), .CHUNK(2)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .in_mode   (a_in_mode),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data),
        .out_ovf   (a_out_ovf)
    );

    chunked_twos_negator #(.WIDTH(16), .CHUNK(4)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .in_mode   (b_in_mode),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .out_ovf   (b_out_ovf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitors: pop expectations on each output handshake
    always @(negedge clk) begin
        exp_t e;
        if (!rst && a_out_valid && a_out_ready) begin
            a_hs_cyc = cyc + 1;
            if (qa.size() == 0) begin
                chk("a_unexpected_output", 32'd1, 32'd0);
            end else begin
                e = qa.pop_front();
                chk("a_data", {26'd0, a_out_data}, {26'd0, e.d[5:0]});
                chk("a_ovf", {31'd0, a_out_ovf}, {31'd0, e.ovf});
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && b_out_valid && b_out_ready) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_output", 32'd1, 32'd0);
            end else begin
                e = qb.pop_front();
                chk("b_data", {16'd0, b_out_data}, {16'd0, e.d});
                chk("b_ovf", {31'd0, b_out_ovf}, {31'd0, e.ovf});
            end
        end
    end

    // Present one operand (called just after a rising edge) and wait for acceptance
    task automatic send_a(input logic [5:0] d, input logic [1:0] m,
                          input logic [5:0] ed, input logic eo);
        int   n;
        logic hit;
        exp_t e;
        e.d = {10'd0, ed};
        e.ovf = eo;
        qa.push_back(e);
        a_in_valid = 1'b1;
        a_in_data  = d;
        a_in_mode  = m;
        hit = 1'b0;
        n = 0;
        while (!hit && n < 100) begin
            @(negedge clk);
            hit = a_in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!hit) chk("a_accept_timeout", 32'd0, 32'd1);
        a_acc_cyc  = cyc;
        a_in_valid = 1'b0;
    endtask

    task automatic drain_a();
        int n = 0;
        while ((qa.size() != 0 || !a_in_ready) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) chk("a_drain_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int   n;
        logic hit;
        exp_t e;

        rst = 1'b1;
        a_in_valid = 1'b0; a_in_data = '0; a_in_mode = '0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_data = '0; b_in_mode = '0; b_out_ready = 1'b1;
        repeat (3) @(posedge clk);

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
        chk("rst_out_data",  {26'd0, a_out_data},  32'd0);
        chk("rst_out_ovf",   {31'd0, a_out_ovf},   32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", {31'd0, a_in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Negate with latency check
        send_a(6'b000101, MODE_NEG, 6'b111011, 1'b0);
        drain_a();
        chk("a_latency", a_hs_cyc - a_acc_cyc, 32'd4);

        // Abs and pass
        send_a(6'b110110, MODE_ABS,  6'b001010, 1'b0);
        send_a(6'b001010, MODE_ABS,  6'b001010, 1'b0);
        send_a(6'b101010, MODE_PASS, 6'b101010, 1'b0);

        // Most-negative, zero, and mode 11
        send_a(6'b100000, MODE_NEG, A_MIN_RES, A_MIN_OVF);
        send_a(6'b000000, MODE_NEG, 6'b000000, 1'b0);
        send_a(6'b000001, 2'b11,    6'b111111, 1'b0);
        drain_a();

        // Output stall in DONE while a new operand waits upstream
        a_out_ready = 1'b0;
        send_a(6'b000011, MODE_NEG, 6'b111101, 1'b0);
        n = 0;
        while (!a_out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("stall_valid_seen", {31'd0, a_out_valid}, 32'd1);
        a_in_valid = 1'b1; a_in_data = 6'b000111; a_in_mode = MODE_NEG;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_out_valid", {31'd0, a_out_valid}, 32'd1);
            chk("stall_out_data",  {26'd0, a_out_data},  {26'd0, 6'b111101});
            chk("stall_in_ready",  {31'd0, a_in_ready},  32'd0);
        end
        @(posedge clk);
        #1;
        e.d = {10'd0, 6'b111001};
        e.ovf = 1'b0;
        qa.push_back(e);
        a_out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("post_hs_in_ready",  {31'd0, a_in_ready},  32'd1);
        chk("post_hs_out_valid", {31'd0, a_out_valid}, 32'd0);
        @(negedge clk);
        chk("next_accepted", {31'd0, a_in_ready}, 32'd0);
        @(posedge clk);
        #1 a_in_valid = 1'b0;
        drain_a();

        // Reset during CALC aborts the transaction
        send_a(6'b000001, MODE_NEG, 6'b111111, 1'b0);
        rst = 1'b1;
        qa.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_out_valid", {31'd0, a_out_valid}, 32'd0);
        chk("abort_in_ready",  {31'd0, a_in_ready},  32'd1);
        chk("abort_out_data",  {26'd0, a_out_data},  32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("abort_no_pulse", {31'd0, a_out_valid}, 32'd0);
        end
        @(posedge clk);
        #1;
        send_a(6'b001001, MODE_NEG, 6'b110111, 1'b0);
        drain_a();

        // Wide instance: back-to-back directed vectors
        for (int i = 0; i < NB; i++) begin
            e.d = bv_e[i];
            e.ovf = bv_o[i];
            qb.push_back(e);
            b_in_valid = 1'b1;
            b_in_data  = bv_d[i];
            b_in_mode  = bv_m[i];
            hit = 1'b0;
            n = 0;
            while (!hit && n < 100) begin
                @(negedge clk);
                hit = b_in_ready;
                @(posedge clk);
                #1;
                n++;
            end
            if (!hit) chk("b_accept_timeout", 32'd0, 32'd1);
            b_acc.push_back(cyc);
        end
        b_in_valid = 1'b0;
        n = 0;
        while ((qb.size() != 0 || !b_in_ready) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) chk("b_drain_timeout", 32'd0, 32'd1);
        for (int i = 1; i < NB; i++) begin
            chk("b_issue_interval", b_acc[i] - b_acc[i-1], 32'd6);
        end

        chk("a_queue_empty", qa.size(), 32'd0);
        chk("b_queue_empty", qb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
